// File: rtl/piece_queue_ctrl_pkg.sv
// Shared piece encoding, randomizer constants and FSM state type for the piece queue.
package piece_queue_ctrl_pkg;

    localparam int          PIECE_COUNT     = 7;
    localparam logic [2:0]  TETROMINO_EMPTY = 3'd7;
    localparam logic [15:0] LFSR_TAP_MASK   = 16'hB400;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_IDLE,
        ST_RESP
    } pq_state_t;

    // Next candidate in the 0..6 ring used when a bag slot is already taken.
    function automatic logic [2:0] piece_wrap_inc(input logic [2:0] p);
        return (p == 3'd6) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/piece_queue_ctrl_bag_randomizer.sv
// 7-bag randomizer: free-running Galois LFSR plus bag mask, one candidate tested per cycle.
module piece_queue_ctrl_bag_randomizer
    import piece_queue_ctrl_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       draw_req,
    output logic       draw_valid,
    output logic [2:0] draw_piece
);

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0]            lfsr;
    logic [PIECE_COUNT-1:0] mask;
    logic [PIECE_COUNT-1:0] mask_set;
    logic                   busy;
    logic [2:0]             cand;
    logic [2:0]             cand_now;

    // A fresh draw samples the LFSR; a draw in progress walks the ring.
    always_comb begin
        cand_now   = busy ? cand : ((lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0]);
        draw_valid = (busy || draw_req) && !mask[cand_now];
        draw_piece = cand_now;
        mask_set   = mask | (PIECE_COUNT'(1) << cand_now);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
            mask <= '0;
            busy <= 1'b0;
            cand <= 3'd0;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAP_MASK : 16'h0000);
            if (draw_valid) begin
                busy <= 1'b0;
                mask <= (&mask_set) ? '0 : mask_set;
            end else if (busy || draw_req) begin
                busy <= 1'b1;
                cand <= piece_wrap_inc(cand_now);
            end
        end
    end

endmodule

// File: rtl/piece_queue_ctrl.sv
// Tetromino scheduler: preview queue, hold slot and lockout, answering spawn/hold requests.
//   state   | meaning
//   ST_FILL | drawing pieces into the queue tail until PREVIEW_DEPTH entries are valid
//   ST_IDLE | queue full, ready=1, accepting spawn/hold requests
//   ST_RESP | resp_valid pulse; back to FILL if the queue was popped, else IDLE
module piece_queue_ctrl
    import piece_queue_ctrl_pkg::*;
#(
    parameter int          PREVIEW_DEPTH = 3,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spawn_req,
    input  logic                       hold_req,
    output logic                       ready,
    output logic                       resp_valid,
    output logic [2:0]                 resp_piece,
    output logic                       resp_from_hold,
    output logic [2:0]                 cur_piece,
    output logic [2:0]                 hold_piece,
    output logic                       hold_used,
    output logic [3*PREVIEW_DEPTH-1:0] next_pieces
);

    localparam int            CW   = $clog2(PREVIEW_DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(PREVIEW_DEPTH - 1);

    pq_state_t     state;
    logic          popped;
    logic [CW-1:0] count;
    logic [2:0]    queue [PREVIEW_DEPTH];

    logic       draw_req;
    logic       draw_valid;
    logic [2:0] draw_piece;
    logic       do_spawn;
    logic       do_hold;
    logic       do_pop;

    piece_queue_ctrl_bag_randomizer #(
        .LFSR_SEED(LFSR_SEED)
    ) u_bag (
        .clk       (clk),
        .rst       (rst),
        .draw_req  (draw_req),
        .draw_valid(draw_valid),
        .draw_piece(draw_piece)
    );

    // Spawn has priority; a swap leaves the queue alone, a first hold pops it.
    always_comb begin
        draw_req = (state == ST_FILL);
        do_spawn = (state == ST_IDLE) && spawn_req;
        do_hold  = (state == ST_IDLE) && !spawn_req && hold_req && !hold_used
                   && (cur_piece != TETROMINO_EMPTY);
        do_pop   = do_spawn || (do_hold && (hold_piece == TETROMINO_EMPTY));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_FILL;
            popped         <= 1'b0;
            count          <= '0;
            ready          <= 1'b0;
            resp_valid     <= 1'b0;
            resp_piece     <= TETROMINO_EMPTY;
            resp_from_hold <= 1'b0;
            cur_piece      <= TETROMINO_EMPTY;
            hold_piece     <= TETROMINO_EMPTY;
            hold_used      <= 1'b0;
            for (int i = 0; i < PREVIEW_DEPTH; i++) queue[i] <= TETROMINO_EMPTY;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                ST_FILL: begin
                    if (draw_valid) begin
                        for (int i = 0; i < PREVIEW_DEPTH; i++)
                            if (CW'(i) == count) queue[i] <= draw_piece;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (do_spawn || do_hold) begin
                        state      <= ST_RESP;
                        ready      <= 1'b0;
                        resp_valid <= 1'b1;
                        popped     <= do_pop;
                        if (do_pop) begin
                            resp_piece     <= queue[0];
                            cur_piece      <= queue[0];
                            resp_from_hold <= 1'b0;
                            for (int i = 0; i < PREVIEW_DEPTH - 1; i++) queue[i] <= queue[i+1];
                            queue[PREVIEW_DEPTH-1] <= TETROMINO_EMPTY;
                            count <= LAST;
                        end else begin
                            resp_piece     <= hold_piece;
                            cur_piece      <= hold_piece;
                            resp_from_hold <= 1'b1;
                        end
                        if (do_hold) begin
                            hold_piece <= cur_piece;
                            hold_used  <= 1'b1;
                        end else begin
                            hold_used  <= 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    state <= popped ? ST_FILL : ST_IDLE;
                    ready <= !popped;
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_next
        assign next_pieces[3*g +: 3] = queue[g];
    end

endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Directed bench for piece_queue_ctrl: boot fill, bag property, hold/swap/lockout, contention, reset mid-fill.
module tb_piece_queue_ctrl;

    localparam int         PD     = 3;
    localparam logic [8:0] BOOT_Q = 9'h081;  // seed ACE1 draws 1,0,2 in 5 cycles
    localparam logic [8:0] ALL_E  = 9'h1FF;

    logic          clk = 1'b0;
    logic          rst;
    logic          spawn_req;
    logic          hold_req;
    logic          ready;
    logic          resp_valid;
    logic [2:0]    resp_piece;
    logic          resp_from_hold;
    logic [2:0]    cur_piece;
    logic [2:0]    hold_piece;
    logic          hold_used;
    logic [3*PD-1:0] next_pieces;

    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;

    always #5 clk = ~clk;

    piece_queue_ctrl #(.PREVIEW_DEPTH(PD), .LFSR_SEED(16'hACE1)) dut (
        .clk           (clk),
        .rst           (rst),
        .spawn_req     (spawn_req),
        .hold_req      (hold_req),
        .ready         (ready),
        .resp_valid    (resp_valid),
        .resp_piece    (resp_piece),
        .resp_from_hold(resp_from_hold),
        .cur_piece     (cur_piece),
        .hold_piece    (hold_piece),
        .hold_used     (hold_used),
        .next_pieces   (next_pieces)
    );

    always @(posedge clk) begin
        #1;
        if (resp_valid) resp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_timeout", ready, 1);
    endtask

    task automatic pulse(input logic s, input logic h);
        spawn_req = s;
        hold_req  = h;
        @(negedge clk);
        spawn_req = 1'b0;
        hold_req  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_valid"}, resp_valid, 0);
        chk({tag, "_resp"}, resp_piece, 7);
        chk({tag, "_from_hold"}, resp_from_hold, 0);
        chk({tag, "_cur"}, cur_piece, 7);
        chk({tag, "_hold"}, hold_piece, 7);
        chk({tag, "_used"}, hold_used, 0);
        chk({tag, "_next"}, next_pieces, ALL_E);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         cyc;
        int         r0;
        int         seq[$];
        logic [7:0] m;
        logic [2:0] head, x, y, z, w, v;
        logic [8:0] q;

        rst = 1'b1; spawn_req = 1'b0; hold_req = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        wait_ready(cyc);
        chk("boot_cycles", cyc, 5);
        chk("boot_queue", next_pieces, BOOT_Q);
        chk("boot_hold", hold_piece, 7);
        chk("boot_used", hold_used, 0);
        m = '0;
        for (int i = 0; i < PD; i++) m[next_pieces[3*i +: 3]] = 1'b1;
        chk("boot_distinct", ($countones(m[6:0]) == 3) && !m[7], 1);

        // hold with nothing in play is ignored
        r0 = resp_cnt;
        pulse(0, 1);
        repeat (2) @(negedge clk);
        chk("hold_no_cur_resp", resp_cnt - r0, 0);
        chk("hold_no_cur_hold", hold_piece, 7);
        chk("hold_no_cur_ready", ready, 1);

        for (int k = 0; k < 14; k++) begin
            head = next_pieces[2:0];
            pulse(1, 0);
            chk("spawn_valid", resp_valid, 1);
            chk("spawn_piece", resp_piece, head);
            chk("spawn_cur", cur_piece, head);
            chk("spawn_from_hold", resp_from_hold, 0);
            seq.push_back(int'(head));
            wait_ready(cyc);
        end
        for (int i = 0; i < PD; i++) seq.push_back(int'(next_pieces[3*i +: 3]));
        for (int wdw = 0; wdw < 14; wdw += 7) begin
            m = '0;
            for (int i = 0; i < 7; i++) m[3'(seq[wdw+i])] = 1'b1;
            chk("bag_window", m, 8'h7F);
        end

        x = cur_piece;
        y = next_pieces[2:0];
        pulse(0, 1);
        chk("hold1_valid", resp_valid, 1);
        chk("hold1_piece", resp_piece, y);
        chk("hold1_from_hold", resp_from_hold, 0);
        chk("hold1_hold", hold_piece, x);
        chk("hold1_used", hold_used, 1);
        chk("hold1_cur", cur_piece, y);
        wait_ready(cyc);

        r0 = resp_cnt;
        pulse(0, 1);
        repeat (3) @(negedge clk);
        chk("lockout_resp", resp_cnt - r0, 0);
        chk("lockout_cur", cur_piece, y);
        chk("lockout_hold", hold_piece, x);
        chk("lockout_used", hold_used, 1);

        z = next_pieces[2:0];
        pulse(1, 0);
        chk("unlock_used", hold_used, 0);
        chk("unlock_cur", cur_piece, z);
        wait_ready(cyc);

        q = next_pieces;
        pulse(0, 1);
        chk("swap_valid", resp_valid, 1);
        chk("swap_piece", resp_piece, x);
        chk("swap_from_hold", resp_from_hold, 1);
        chk("swap_hold", hold_piece, z);
        chk("swap_cur", cur_piece, x);
        chk("swap_used", hold_used, 1);
        wait_ready(cyc);
        chk("swap_ready_cycles", cyc, 1);
        chk("swap_queue", next_pieces, q);

        // spawn wins over hold; a hold during FILL is dropped
        w = next_pieces[2:0];
        r0 = resp_cnt;
        pulse(1, 1);
        chk("cont_valid", resp_valid, 1);
        chk("cont_piece", resp_piece, w);
        chk("cont_from_hold", resp_from_hold, 0);
        chk("cont_used", hold_used, 0);
        chk("cont_hold", hold_piece, z);
        @(negedge clk);
        chk("cont_fill_ready", ready, 0);
        pulse(0, 1);
        wait_ready(cyc);
        repeat (2) @(negedge clk);
        chk("cont_resp_count", resp_cnt - r0, 1);
        chk("drop_used", hold_used, 0);
        chk("drop_hold", hold_piece, z);
        chk("drop_cur", cur_piece, w);

        v = next_pieces[2:0];
        pulse(1, 1);
        chk("cont2_piece", resp_piece, v);
        chk("cont2_hold", hold_piece, z);
        chk("cont2_used", hold_used, 0);
        wait_ready(cyc);

        pulse(1, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midfill");
        rst = 1'b0;
        wait_ready(cyc);
        chk("reboot_cycles", cyc, 5);
        chk("reboot_queue", next_pieces, BOOT_Q);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piece_queue_ctrl.md
Name: piece_queue_ctrl

Overview:
- Schedules the tetromino stream for game_control.
- Owns the 7-bag randomizer, the next-piece preview queue, the hold slot and the hold lockout flag.
- game_control issues spawn and hold requests. This block answers each with the piece to place, and drives t_next_disp / t_hold_disp / hold_used_out upstream of the renderer.

Parameters:
- PREVIEW_DEPTH, 3: number of queued next pieces (1..6).
- LFSR_SEED, 16'hACE1: randomizer seed. A value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- spawn_req  in  1  one-cycle pulse: current piece locked, deliver the next piece.
- hold_req  in  1  one-cycle pulse: hold key pressed.
- ready  out  1  idle and queue full; requests are accepted only while ready=1.
- resp_valid  out  1  one-cycle pulse: resp_piece is valid.
- resp_piece  out  3  delivered piece idx (0..6 = I,J,L,O,S,T,Z; 7 = `TETROMINO_EMPTY).
- resp_from_hold  out  1  qualifies resp_valid: piece came from the hold slot.
- cur_piece  out  3  piece currently in play (last delivered).
- hold_piece  out  3  hold slot contents.
- hold_used  out  1  hold lockout flag.
- next_pieces  out  3*PREVIEW_DEPTH  preview queue; [2:0] is the head.

Behaviour:
- Reset values: ready=0, resp_valid=0, resp_piece=7, resp_from_hold=0, cur_piece=7, hold_piece=7, hold_used=0, all next_pieces=7, bag mask=0, LFSR=LFSR_SEED. After reset the FSM enters FILL.
- Reset is honoured in any state; it aborts FILL and discards any partial draw.
- LFSR: 16-bit Galois, mask 16'hB400. It advances every cycle, free-running, so request timing adds entropy.
- Draw, one candidate tested per cycle:
  - On draw start, cand = lfsr[2:0]; a value of 7 maps to 0.
  - If mask[cand] is set, cand = (cand+1) mod 7 on the next cycle.
  - Otherwise the piece is emitted and mask[cand] is set.
  - When all 7 mask bits are set after an emit, the mask clears in the same cycle.
  - A draw completes in 1..7 cycles.
- FSM states: FILL, IDLE, RESP.
- FILL:
  - Each draw appends to the queue tail.
  - Stays in FILL until the queue holds PREVIEW_DEPTH valid entries, then goes to IDLE.
  - Initial fill completes in ≤ 7*PREVIEW_DEPTH+2 cycles.
- IDLE (ready=1):
  - spawn_req: pop the queue head into resp_piece and cur_piece, resp_from_hold=0, clear hold_used. Go to RESP.
  - hold_req with hold_used=1 or cur_piece=7: ignored. No response, no state change.
  - hold_req with hold_used=0 and hold_piece=7: hold_piece<=cur_piece, then pop the head into resp_piece/cur_piece, resp_from_hold=0, hold_used<=1. Go to RESP.
  - hold_req with hold_used=0 and hold_piece≠7: swap. resp_piece/cur_piece<=hold_piece, hold_piece<=old cur_piece, resp_from_hold=1, hold_used<=1. The queue is untouched. Go to RESP.
  - spawn_req and hold_req in the same cycle: spawn wins, hold is dropped.
- RESP:
  - resp_valid=1 for exactly one cycle, so latency is request edge +1.
  - Next state is FILL if the queue was popped, otherwise IDLE.
- Requests arriving while ready=0 are dropped silently. game_control must wait for ready.
- Queue pop shifts entries toward the head. The vacated tail entry reads 7 until refilled.
- Bag guarantee: draws 7k+1..7k+7 are a permutation of 0..6.

Decomposition:
- GLOBAL.sv: reuse `TETROMINO_EMPTY and the 3-bit piece idx encoding. Add a `PIECE_COUNT 7 define and the LFSR tap mask define.
- Sub-module bag_randomizer: LFSR, bag mask and a draw_req/draw_valid/draw_piece handshake. The parent holds the queue, hold slot and FSM.

Test Plan:
- Reset init: hold rst 10 cycles, release. Required: ready=1 within 23 cycles (PREVIEW_DEPTH=3), hold_piece=7, hold_used=0, three distinct next idx values <7.
- Bag property: 14 spawn_reqs, each issued after ready, collecting all delivered pieces. Required: in the sequence formed by the initial queue followed by the deliveries, each 7-draw window is a permutation of 0..6.
- First hold: spawn (cur=X, next head=Y), then hold_req. Required: resp_piece=Y, resp_from_hold=0, hold_piece=X, hold_used=1.
- Lockout, then swap:
  - A second hold_req gives no resp_valid; cur and hold are unchanged.
  - A spawn then gives hold_used=0 with new cur=Z.
  - hold_req then gives resp_piece=X, resp_from_hold=1, hold_piece=Z, and the queue is unchanged.
- Contention: spawn_req and hold_req in the same cycle. Required: spawn response only, hold_used=0. A hold_req pulsed while ready=0 (during FILL) is dropped.
- Reset mid-FILL: assert rst 2 cycles after a spawn. Required: all outputs return to reset values next cycle, and the fill restarts from LFSR_SEED with the same sequence as the first boot.
